// File: rtl/ram_stream_reader.sv
// Sequential RAM read master: streams `length` words from `base_addr`; first word 3 cycles after start.
// Backpressure: a 2-entry FIFO plus the in-flight read gate issue, so stalls cost no bandwidth.

module fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_vld,
  input  logic [WIDTH-1:0]             push_dat,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head_dat,
  output logic                         head_vld,
  output logic [$clog2(DEPTH+1)-1:0]   cnt
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
  endfunction

  assign head_dat = mem[rd_ptr];
  assign head_vld = (cnt != '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_vld) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop && head_vld) rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(push_vld) - CW'(pop && head_vld);
    end
  end
endmodule

module ram_stream_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_a,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_d,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state, state_n;
  logic                  done_n;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic [ADDR_WIDTH:0]   pop_cnt;
  logic                  inflight;
  logic                  issue;
  logic                  pop;
  logic [1:0]            fifo_cnt;
  logic [2:0]            occ;

  assign ram_we = 1'b0;
  assign ram_d  = '0;
  assign busy   = (state != IDLE);
  assign ram_a  = (state == RUN) ? rd_addr : '0;

  assign pop = out_valid & out_ready;
  // Occupancy after this cycle if nothing new is issued; must leave room for one more word.
  assign occ   = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue = (state == RUN) && (issue_cnt != len_q) && (occ < 3'd2);

  assign out_last = out_valid && (pop_cnt == len_q - (ADDR_WIDTH+1)'(1));

  fifo #(.WIDTH(DATA_WIDTH), .DEPTH(2)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (inflight),
    .push_dat (ram_q),
    .pop      (pop),
    .head_dat (out_data),
    .head_vld (out_valid),
    .cnt      (fifo_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      done  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) done_n  = 1'b1;
          else              state_n = RUN;
        end
      end
      RUN: begin
        if (issue && (issue_cnt == len_q - (ADDR_WIDTH+1)'(1))) state_n = DRAIN;
      end
      DRAIN: begin
        if (pop && out_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_addr   <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      pop_cnt   <= '0;
      inflight  <= 1'b0;
    end else begin
      if ((state == IDLE) && start) begin
        rd_addr   <= base_addr;
        len_q     <= length;
        issue_cnt <= '0;
        pop_cnt   <= '0;
      end else begin
        if (issue) begin
          rd_addr   <= rd_addr + ADDR_WIDTH'(1);
          issue_cnt <= issue_cnt + (ADDR_WIDTH+1)'(1);
        end
        if (pop) pop_cnt <= pop_cnt + (ADDR_WIDTH+1)'(1);
      end
      inflight <= issue;
    end
  end
endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: registered-read RAM model, scoreboard of expected words per transfer.
module tb_ram_stream_reader;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, ram_we, out_valid, out_last;
  logic          out_ready = 1'b0;
  logic [AW-1:0] ram_a;
  logic [DW-1:0] ram_d, ram_q, out_data;

  logic [DW-1:0] mem [1<<AW];
  logic          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  logic [DW-1:0] exp_q[$];
  logic          exp_last_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  ram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .ram_a     (ram_a),
    .ram_we    (ram_we),
    .ram_d     (ram_d),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_a];

  function automatic logic [DW-1:0] word_at(input int a);
    return DW'((a % (1 << AW)) + 'h100);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"},  out_last, 0);
    chk({tag, "_data"},  out_data, 0);
    chk({tag, "_ram_a"}, ram_a, 0);
  endtask

  // mode 0: out_ready held high; mode 1: out_ready follows pat.
  // inject 1: extra start in cycle 2; inject 2: reset after the second word.
  task automatic run_xfer(input int base, input int len, input int mode, input int inject);
    int   cyc, got, done_cyc, first_cyc, budget;
    logic stalled, rdy, do_reset;
    logic [DW-1:0] held_d, e_d;
    logic held_l, e_l;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(word_at(base + i));
      exp_last_q.push_back(i == len - 1);
    end
    base_addr = AW'(base);
    length    = (AW+1)'(len);
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cyc = 1; got = 0; done_cyc = -1; first_cyc = -1; stalled = 0; do_reset = 0;
    budget = len * 3 + 20;
    held_d = '0; held_l = 0;
    while (done_cyc < 0 && cyc < budget) begin
      rdy       = (mode == 0) ? 1'b1 : pat[(cyc - 1) % 6];
      out_ready = rdy;
      start     = (inject == 1 && cyc == 2);
      if (start) begin
        base_addr = AW'(500);
        length    = (AW+1)'(3);
      end
      if (cyc == 1) begin
        chk("busy_c1", busy, len != 0);
        chk("done_c1", done, len == 0);
      end else if (done) chk("busy_at_done", busy, 0);
      else chk("busy_mid", busy, 1);
      if (mode == 0 && cyc <= len) chk("ram_a_seq", ram_a, (base + cyc - 1) % (1 << AW));
      chk("ram_we", ram_we, 0);
      chk("ram_d", ram_d, 0);
      chk("last_wo_valid", out_last & ~out_valid, 0);
      chk("fifo_bound", dut.fifo_cnt <= 2, 1);
      if (stalled) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held_d);
        chk("hold_last", out_last, held_l);
      end
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (out_valid && rdy) begin
        chk("word_avail", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_d = exp_q.pop_front();
          e_l = exp_last_q.pop_front();
          chk("word_data", out_data, e_d);
          chk("word_last", out_last, e_l);
        end
        if (mode == 0) chk("word_cycle", cyc, 3 + got);
        got++;
        if (inject == 2 && got == 2) do_reset = 1;
      end
      stalled = out_valid && !rdy;
      held_d  = out_data;
      held_l  = out_last;
      if (done) done_cyc = cyc;
      else begin
        @(posedge clk); #1;
        cyc++;
        start = 1'b0;
        if (do_reset) begin
          reset_n = 1'b0;
          #1;
          chk_all_zero("in_reset");
          @(posedge clk); #1;
          reset_n = 1'b1;
          exp_q.delete();
          exp_last_q.delete();
          repeat (3) begin
            chk_all_zero("post_reset");
            chk("post_reset_state", 32'(dut.state), 0);
            @(posedge clk); #1;
          end
          return;
        end
      end
    end
    chk("timeout", done_cyc >= 0, 1);
    chk("valid_at_done", out_valid, 0);
    chk("words_left", exp_q.size(), 0);
    chk("words_got", got, len);
    if (len > 0) chk("first_valid_cycle", first_cyc, 3);
    if (mode == 0) chk("done_cycle", done_cyc, (len == 0) ? 1 : len + 3);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = word_at(i);
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_ram_we", ram_we, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    run_xfer(4, 5, 0, 0);
    run_xfer(4, 5, 1, 0);
    run_xfer(1022, 4, 0, 0);
    run_xfer(0, 0, 0, 0);
    run_xfer(0, 1024, 0, 0);
    run_xfer(10, 6, 0, 1);
    run_xfer(20, 6, 0, 2);
    run_xfer(200, 3, 0, 0);
    run_xfer(7, 4, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_stream_reader.md
# ram_stream_reader

Sequential read master for the team's single-port inferred RAM (registered read, one-cycle latency). On a start command it reads `length` consecutive words beginning at `base_addr` and presents them as a valid/ready stream with backpressure. Inference and layer control units use it to pull weights, biases and activations out of RAM without handling read latency themselves. It owns the RAM address/write-enable/data pins for the duration of a transfer. It never writes.

## Interface
- `ADDR_WIDTH`, 10, RAM address width
- `DATA_WIDTH`, 16, RAM word width
- `clk`  in  1  rising-edge clock, shared with the RAM
- `reset_n`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle command; sampled only in IDLE
- `base_addr`  in  ADDR_WIDTH  first word address; latched on accepted `start`
- `length`  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; latched on accepted `start`
- `busy`  out  1  high from the cycle after an accepted `start` until the transfer completes
- `done`  out  1  one-cycle pulse at completion
- `ram_a`  out  ADDR_WIDTH  RAM address
- `ram_we`  out  1  constant 0
- `ram_d`  out  DATA_WIDTH  constant 0
- `ram_q`  in  DATA_WIDTH  RAM read data; valid the cycle after the address is presented
- `out_data`  out  DATA_WIDTH  stream data
- `out_valid`  out  1  stream valid
- `out_ready`  in  1  stream ready from the consumer
- `out_last`  out  1  high with the final word of a transfer

## Operation
- States:
  - IDLE: an accepted `start` with `length`≠0 moves to RUN. With `length`=0 the block stays in IDLE and pulses `done` the next cycle; no reads are issued.
  - RUN: the block issues reads until `length` have been issued. It then moves to DRAIN.
  - DRAIN: the block waits for the in-flight read and the buffer to empty. It moves to IDLE after the last handshake.
- A `start` seen outside IDLE is ignored.
- Read address counter `rd_addr`:
  - Loaded with `base_addr`.
  - `ram_a` = `rd_addr` in RUN; 0 in IDLE and DRAIN.
  - Increments modulo 2^ADDR_WIDTH on each issue, so transfers wrap from 2^ADDR_WIDTH−1 to 0.
- Output buffer: a 2-entry FIFO, with `out_data` taken from the FIFO head.
  - `inflight` is a 1-bit flag meaning a read issued last cycle.
  - When `inflight` is set, `ram_q` is pushed into the FIFO at the cycle end.
- Issue rule: issue in RUN when `count + inflight − pop < 2`, where `pop` = `out_valid & out_ready`. The FIFO therefore never overflows.
- Handshake:
  - A word transfers on a cycle where `out_valid` and `out_ready` are both high.
  - While `out_valid` is high and `out_ready` is low, `out_data`/`out_last` hold stable and `out_valid` stays high.
- `out_last` is driven by a popped-word counter equal to `length`−1. It is never asserted when `out_valid` is low.
- Reset (async, any time, including mid-transfer) clears everything:
  - State goes to IDLE.
  - FIFO is emptied and `inflight` cleared.
  - Counters are cleared.
  - All outputs go to 0: `busy`, `done`, `out_valid`, `out_last`, `out_data`, `ram_a`.
  - No partial stream resumes after reset.

## Timing
- Let cycle 0 be the cycle where `start` is accepted.
  - Cycle 1: `busy`=1, `ram_a`=`base_addr`.
  - Cycle 2: `ram_q`=mem[`base_addr`].
  - Cycle 3: `out_valid`=1. First-word latency is 3 cycles.
- With `out_ready` held high, throughput is 1 word/cycle:
  - The last word is presented in cycle `length`+2.
  - In cycle `length`+3, `done`=1 and `busy`=0.
- `done` pulses in the cycle after the final handshake, coincident with the return to IDLE. A new `start` is accepted in that same cycle.
- Backpressure costs no bandwidth. After `out_ready` rises, words resume on the next edge with no bubble.
- `length`=0: `done`=1 in cycle 1, `busy` stays 0.

## Test plan
- Basic read:
  - Stimulus: RAM preloaded with mem[i]=i+0x100; `start` with `base_addr`=4, `length`=5, `out_ready`=1.
  - Required: `out_data` 0x104..0x108 in cycles 3..7; `out_last` only in cycle 7; `done` in cycle 8; `ram_we` always 0.
- Backpressure:
  - Stimulus: same transfer; `out_ready` toggles 1,0,0,1,0,1…
  - Required: the same 5 words in order, no loss or duplicate; `out_data` stable while stalled; FIFO never exceeds 2.
- Wrap-around:
  - Stimulus: `base_addr`=1022, `length`=4.
  - Required: `ram_a` sequence 1022, 1023, 0, 1; data mem[1022], mem[1023], mem[0], mem[1].
- Zero/full length:
  - Stimulus: `length`=0, then `length`=1024 at `base_addr`=0 with `out_ready`=1.
  - Required: for `length`=0, `done` in cycle 1 and no `out_valid`; for `length`=1024, all 1024 words are delivered and `done` arrives in cycle 1027.
- Start while busy / reset mid-transfer:
  - Stimulus: `start` during RUN, then `reset_n` low for one cycle after word 2.
  - Required: the second `start` is ignored; after reset all outputs are 0 and the block is IDLE. A fresh `start` is accepted and streams correctly from its new `base_addr`.
